alu_core: RTL and testbench
===========================

Name: alu_core

Overview:
- Datapath ALU of the e800 8-bit CPU. Combines three combinational units: 8-bit add, 16-bit increment and 8-bit NAND.
- Operands come from the 16-bit temporary register content, split into top byte (B) and bottom byte (A).
- The selected unit drives the shared tristate data bus.
- Holds the carry and zero flag registers, which are updated only on add operations.

Parameters:
- DATA_WIDTH, 8, byte width. The bus is two bytes wide (top and bottom). The increment unit is 2*DATA_WIDTH wide.

Ports:
- clock  in  1  system clock; flags update on the rising edge.
- reset  in  1  asynchronous, active-low reset; clears the flags.
- add_out  in  1  drive A+B onto bus_bottom and enable the flag update.
- inc_out  in  1  drive {B,A}+1 onto {bus_top,bus_bottom}.
- nand_out  in  1  drive ~(A&B) onto bus_bottom.
- operand  in  2*DATA_WIDTH  temporary register content: B = operand[15:8], A = operand[7:0].
- bus_top  out(tristate)  DATA_WIDTH  upper bus byte; high-Z unless inc wins.
- bus_bottom  out(tristate)  DATA_WIDTH  lower bus byte; high-Z unless an op is selected.
- carry_flag  out  1  registered carry of the last add.
- zero_flag  out  1  registered zero status of the last add.
- op_conflict  out  1  combinational; high when more than one enable is asserted.

Behaviour:
- Bus drive is purely combinational, with zero latency from enables and operands to the bus.
- With no enable asserted, both bus bytes are high-Z. The external bus has a pull-up and reads all-ones.
- Add: bus_bottom = (A+B) mod 256, bus_top = Z. add_carry = bit 8 of the 9-bit sum.
- Inc: {bus_top,bus_bottom} = ({B,A}+1) mod 65536. Wrap FFFF -> 0000. The carry is discarded and no flag is touched.
- Nand: bus_bottom = ~(A & B) bitwise, bus_top = Z. Flags are not touched.
- Priority when several enables are asserted at once: add > inc > nand. Only the winner drives. op_conflict = 1 in that cycle.
- Flags:
  - On a rising clock edge with add_out = 1: carry_flag <= add_carry, zero_flag <= (sum == 0).
  - This applies even if another enable is also set, because add wins priority.
  - Otherwise both flags hold their value.
- Reset:
  - reset = 0 asynchronously clears carry_flag and zero_flag to 0, without waiting for a clock edge.
  - While reset is low, the flags stay 0 and the add update is ignored.
  - Bus drive stays purely combinational during reset and is unaffected by it.
- Reset released mid-add: the flags load at the first rising edge where reset = 1 and add_out = 1.
- Outputs: the flags are registered. The bus and op_conflict are combinational.

Decomposition:
- Shared package: DATA_WIDTH default and the enable priority encoding as constants.
- One sub-module is natural: alu_flags. It holds the 2-bit flag register with async active-low clear and the add-enable load.
- The three arithmetic units are simple continuous-assign logic inside alu_core.

Test Plan:
1. Reset then add: reset low, then high. operand = 16'h0305, add_out = 1 -> bus_bottom = 08, bus_top = Z. After the edge, carry_flag = 0, zero_flag = 0.
2. Add overflow to zero: operand = 16'h01FF, add_out = 1 -> bus_bottom = 00. After the edge, carry_flag = 1, zero_flag = 1. Drop add_out and pulse nand_out -> flags still 1/1.
3. Increment wrap: operand = 16'h00FF, inc_out = 1 -> bus = 0100. operand = 16'hFFFF -> bus = 0000. Flags unchanged across edges.
4. Nand: operand = 16'hF0CC, nand_out = 1 -> bus_bottom = 3F, bus_top = Z. operand = 16'h0000 -> bus_bottom = FF.
5. Idle and conflict:
   - All enables 0 -> both bytes Z.
   - add_out = inc_out = 1 with operand = 16'h1020 -> bus_bottom = 30, bus_top = Z, op_conflict = 1.
6. Async reset: with flags 1/1, drive reset = 0 between clock edges -> flags go 0 immediately. Holding add_out = 1 with operand = 16'h01FF while reset is low keeps the flags at 0.

Source files
------------

// File: rtl/alu_core_pkg.sv
// Shared constants and types for the e800 datapath ALU.
package alu_core_pkg;

  // Native byte width of the datapath; the bus and increment unit are two bytes.
  localparam int ALU_DATA_WIDTH = 8;

  // Which unit owns the shared bus this cycle. Encoded values double as the
  // priority order: add beats inc beats nand.
  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_INC  = 2'd2,
    OP_NAND = 2'd3
  } op_sel_e;

  // Carry/zero status captured from the adder.
  typedef struct packed {
    logic carry;
    logic zero;
  } alu_flags_t;

  // Resolve simultaneous enables to a single bus owner.
  function automatic op_sel_e op_select(input logic add_en,
                                        input logic inc_en,
                                        input logic nand_en);
    if (add_en)       return OP_ADD;
    else if (inc_en)  return OP_INC;
    else if (nand_en) return OP_NAND;
    else              return OP_NONE;
  endfunction

  // True when two or more enables collide.
  function automatic logic multi_hot3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/alu_flags.sv
// Carry/zero flag register: async active-low clear, loads only on add.
module alu_flags
  import alu_core_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic add_carry,
  input  logic add_zero,
  output logic carry_flag,
  output logic zero_flag
);

  alu_flags_t flags_q;
  alu_flags_t flags_d;

  assign flags_d = '{carry: add_carry, zero: add_zero};

  // Capture adder status when the add unit is active; hold otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    flags_q <= '0;
    else if (load) flags_q <= flags_d;
  end

  assign carry_flag = flags_q.carry;
  assign zero_flag  = flags_q.zero;

endmodule

// File: rtl/alu_core.sv
// e800 datapath ALU: add, 16-bit increment and nand onto the shared tristate bus.
module alu_core
  import alu_core_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      add_out,
  input  logic                      inc_out,
  input  logic                      nand_out,
  input  logic [2*DATA_WIDTH-1:0]   operand,
  output wire  [DATA_WIDTH-1:0]     bus_top,
  output wire  [DATA_WIDTH-1:0]     bus_bottom,
  output logic                      carry_flag,
  output logic                      zero_flag,
  output logic                      op_conflict
);

  localparam int BUS_W = 2 * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] opnd_a;
  logic [DATA_WIDTH-1:0] opnd_b;
  logic [DATA_WIDTH:0]   add_sum;
  logic                  add_carry;
  logic                  add_zero;
  logic [BUS_W-1:0]      inc_sum;
  logic [DATA_WIDTH-1:0] nand_res;
  op_sel_e               op_sel;

  logic                  top_en;
  logic                  bottom_en;
  logic [DATA_WIDTH-1:0] top_val;
  logic [DATA_WIDTH-1:0] bottom_val;

  // Operand split: B is the top byte, A the bottom byte.
  assign opnd_b = operand[BUS_W-1:DATA_WIDTH];
  assign opnd_a = operand[DATA_WIDTH-1:0];

  // Arithmetic units, always evaluating; the selector decides who drives.
  assign add_sum   = {1'b0, opnd_a} + {1'b0, opnd_b};
  assign add_carry = add_sum[DATA_WIDTH];
  assign add_zero  = (add_sum[DATA_WIDTH-1:0] == '0);
  assign inc_sum   = operand + {{(BUS_W-1){1'b0}}, 1'b1};
  assign nand_res  = ~(opnd_a & opnd_b);

  assign op_sel      = op_select(add_out, inc_out, nand_out);
  assign op_conflict = multi_hot3(add_out, inc_out, nand_out);

  // Bus owner mux; only the increment unit ever drives the top byte.
  always_comb begin
    top_en     = 1'b0;
    bottom_en  = 1'b0;
    top_val    = '0;
    bottom_val = '0;
    unique case (op_sel)
      OP_ADD: begin
        bottom_en  = 1'b1;
        bottom_val = add_sum[DATA_WIDTH-1:0];
      end
      OP_INC: begin
        top_en     = 1'b1;
        bottom_en  = 1'b1;
        top_val    = inc_sum[BUS_W-1:DATA_WIDTH];
        bottom_val = inc_sum[DATA_WIDTH-1:0];
      end
      OP_NAND: begin
        bottom_en  = 1'b1;
        bottom_val = nand_res;
      end
      default: ;
    endcase
  end

  // Release the bus when not selected; the board pull-up sets the idle level.
  assign bus_top    = top_en    ? top_val    : {DATA_WIDTH{1'bz}};
  assign bus_bottom = bottom_en ? bottom_val : {DATA_WIDTH{1'bz}};

  alu_flags u_flags (
    .clock      (clock),
    .reset      (reset),
    .load       (add_out),
    .add_carry  (add_carry),
    .add_zero   (add_zero),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag)
  );

endmodule

// File: tb/tb_alu_core.sv
// Bench for alu_core: vector table through a scoreboard queue, plus reset corners.
module tb_alu_core;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        add_out = 1'b0;
  logic        inc_out = 1'b0;
  logic        nand_out = 1'b0;
  logic [15:0] operand = 16'h0000;
  wire  [7:0]  bus_top;
  wire  [7:0]  bus_bottom;
  logic        carry_flag;
  logic        zero_flag;
  logic        op_conflict;

  int n_chk  = 0;
  int n_fail = 0;

  // External bus pull-up: an undriven byte reads FF.
  pullup (bus_top);
  pullup (bus_bottom);

  always #5 clock = ~clock;

  alu_core dut (
    .clock       (clock),
    .reset       (reset),
    .add_out     (add_out),
    .inc_out     (inc_out),
    .nand_out    (nand_out),
    .operand     (operand),
    .bus_top     (bus_top),
    .bus_bottom  (bus_bottom),
    .carry_flag  (carry_flag),
    .zero_flag   (zero_flag),
    .op_conflict (op_conflict)
  );

  typedef struct {
    string       name;
    logic        add;
    logic        inc;
    logic        nnd;
    logic [15:0] opnd;
    logic [7:0]  top;
    logic [7:0]  bot;
    logic        conf;
    logic        carry;   // flags after the clock edge
    logic        zero;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] top;
    logic [7:0] bot;
    logic       conf;
    logic       carry;
    logic       zero;
  } exp_t;

  vec_t vecs[15];
  exp_t sb_q[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic a, input logic i, input logic n, input logic [15:0] op);
    add_out  = a;
    inc_out  = i;
    nand_out = n;
    operand  = op;
  endtask

  initial begin
    exp_t e;

    // name, add, inc, nand, operand, top, bottom, conflict, carry, zero
    vecs[0]  = '{"add_0305",     1,0,0, 16'h0305, 8'hFF, 8'h08, 0, 0, 0};
    vecs[1]  = '{"add_01FF",     1,0,0, 16'h01FF, 8'hFF, 8'h00, 0, 1, 1};
    vecs[2]  = '{"nand_hold",    0,0,1, 16'h01FF, 8'hFF, 8'hFE, 0, 1, 1};
    vecs[3]  = '{"inc_00FF",     0,1,0, 16'h00FF, 8'h01, 8'h00, 0, 1, 1};
    vecs[4]  = '{"inc_wrap",     0,1,0, 16'hFFFF, 8'h00, 8'h00, 0, 1, 1};
    vecs[5]  = '{"nand_F0CC",    0,0,1, 16'hF0CC, 8'hFF, 8'h3F, 0, 1, 1};
    vecs[6]  = '{"nand_0000",    0,0,1, 16'h0000, 8'hFF, 8'hFF, 0, 1, 1};
    vecs[7]  = '{"idle",         0,0,0, 16'h1234, 8'hFF, 8'hFF, 0, 1, 1};
    vecs[8]  = '{"add_inc",      1,1,0, 16'h1020, 8'hFF, 8'h30, 1, 0, 0};
    vecs[9]  = '{"inc_nand",     0,1,1, 16'h1234, 8'h12, 8'h35, 1, 0, 0};
    vecs[10] = '{"add_nand",     1,0,1, 16'h8080, 8'hFF, 8'h00, 1, 1, 1};
    vecs[11] = '{"all_three",    1,1,1, 16'h7F90, 8'hFF, 8'h0F, 1, 1, 0};
    vecs[12] = '{"add_zero",     1,0,0, 16'h0000, 8'hFF, 8'h00, 0, 0, 1};
    vecs[13] = '{"inc_carry8",   0,1,0, 16'h12FF, 8'h13, 8'h00, 0, 0, 1};
    vecs[14] = '{"add_8001",     1,0,0, 16'h8001, 8'hFF, 8'h81, 0, 0, 0};

    // Reset state, including an add request that must be ignored.
    drive(1, 0, 0, 16'h01FF);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_flags", {14'h0, carry_flag, zero_flag}, 16'h0000);
    chk("rst_bus",   {bus_top, bus_bottom}, 16'hFF00);
    @(negedge clock);
    drive(0, 0, 0, 16'h0000);
    reset = 1'b1;

    // Vector table through the scoreboard.
    foreach (vecs[k]) begin
      @(negedge clock);
      drive(vecs[k].add, vecs[k].inc, vecs[k].nnd, vecs[k].opnd);
      sb_q.push_back('{vecs[k].name, vecs[k].top, vecs[k].bot,
                       vecs[k].conf, vecs[k].carry, vecs[k].zero});
      #1;
      e = sb_q[0];
      chk({e.name, "_bus"},  {bus_top, bus_bottom}, {e.top, e.bot});
      chk({e.name, "_conf"}, {15'h0, op_conflict}, {15'h0, e.conf});
      @(posedge clock);
      #1;
      e = sb_q.pop_front();
      chk({e.name, "_flags"}, {14'h0, carry_flag, zero_flag}, {14'h0, e.carry, e.zero});
    end

    // Async clear between edges: set flags to 1/1 first.
    @(negedge clock);
    drive(1, 0, 0, 16'h01FF);
    @(posedge clock);
    #1;
    chk("pre_async", {14'h0, carry_flag, zero_flag}, 16'h0003);
    #2;
    reset = 1'b0;
    #1;
    chk("async_clr", {14'h0, carry_flag, zero_flag}, 16'h0000);
    chk("rst_bus_live", {bus_top, bus_bottom}, 16'hFF00);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_hold_add", {14'h0, carry_flag, zero_flag}, 16'h0000);

    // Release mid-add: no change until the next rising edge, then load.
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rel_pre_edge", {14'h0, carry_flag, zero_flag}, 16'h0000);
    @(posedge clock);
    #1;
    chk("rel_load", {14'h0, carry_flag, zero_flag}, 16'h0003);

    // Inc with flags set must leave them alone across an edge.
    @(negedge clock);
    drive(0, 1, 0, 16'h00FF);
    @(posedge clock);
    #1;
    chk("inc_keep", {14'h0, carry_flag, zero_flag}, 16'h0003);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
